// File: rtl/baud_tick_gen.sv
// Baud-rate oversample tick generator: divides clk down to a 16x-oversample
// strobe and derives mid-bit and bit-boundary ticks from a 4-bit oversample index.
module baud_tick_gen (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] max_value,
   input  logic        resync,
   output logic        sample_enable,
   output logic        mid_tick,
   output logic        bit_tick,
   output logic [3:0]  sample_cnt,
   output logic        busy
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [15:0] div_cnt_q, div_cnt_d;
   logic [3:0]  sample_cnt_q, sample_cnt_d;
   logic [15:0] max_q;

   logic [15:0] eff_max;
   logic        run;
   logic        rate_change;
   logic        period_end;

   assign run         = (state_q == RUN);
   assign eff_max     = (max_q == 16'd0) ? 16'd1 : max_q;
   assign rate_change = (max_q != max_value);
   assign period_end  = (div_cnt_q == eff_max - 16'd1);

   // A strobe is only emitted when the count actually advances, so resync,
   // a rate change or a falling enable can never produce an orphan pulse.
   assign sample_enable = run && enable && !resync && !rate_change && period_end;
   assign mid_tick      = sample_enable && (sample_cnt_q == 4'd7);
   assign bit_tick      = sample_enable && (sample_cnt_q == 4'd15);
   assign sample_cnt    = sample_cnt_q;
   assign busy          = run;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
      state_d      = state_q;
      div_cnt_d    = div_cnt_q;
      sample_cnt_d = sample_cnt_q;
      case (state_q)
         IDLE: begin
            div_cnt_d    = 16'd0;
            sample_cnt_d = 4'd0;
            if (enable) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d      = IDLE;
               div_cnt_d    = 16'd0;
               sample_cnt_d = 4'd0;
            end else if (resync || rate_change) begin
               div_cnt_d    = 16'd0;
               sample_cnt_d = 4'd0;
            end else if (sample_enable) begin
               div_cnt_d    = 16'd0;
               sample_cnt_d = sample_cnt_q + 4'd1;
            end else begin
               div_cnt_d = div_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d      = IDLE;
            div_cnt_d    = 16'd0;
            sample_cnt_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         div_cnt_q    <= 16'd0;
         sample_cnt_q <= 4'd0;
         max_q        <= 16'd0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         sample_cnt_q <= sample_cnt_d;
         max_q        <= max_value;
      end
   end

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-002 clk  input  1  system clock (50 MHz); all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  runs the generator when 1 and holds it idle when 0.
REQ-005 max_value  input  16  divider period in clk cycles per 16x-oversample tick, driven from the baud selection table.
REQ-006 resync  input  1  single-cycle pulse that realigns the bit phase, driven by the receiver on start-bit edge.
REQ-007 sample_enable  output  1  one-cycle pulse once per oversample period.
REQ-008 mid_tick  output  1  one-cycle pulse coincident with the sample_enable where sample_cnt becomes 8 (mid-bit).
REQ-009 bit_tick  output  1  one-cycle pulse coincident with the sample_enable where sample_cnt wraps 15 -> 0 (bit boundary).
REQ-010 sample_cnt  output  4  current oversample index, 0..15.
REQ-011 busy  output  1  1 while in state RUN.

Function
REQ-012 The state machine SHALL have two states: IDLE and RUN.
REQ-013 IDLE -> RUN SHALL occur on the first clk edge with enable=1.
REQ-014 RUN -> IDLE SHALL occur on the first clk edge with enable=0.
REQ-015 On entering or staying in IDLE, div_cnt (16 bit) and sample_cnt SHALL be cleared, and sample_enable, mid_tick and bit_tick SHALL be 0.
REQ-016 In RUN, div_cnt SHALL increment each cycle.
REQ-017 When div_cnt = eff_max-1, div_cnt SHALL instead load 0 and sample_enable SHALL be 1 for that cycle, giving a period of exactly eff_max cycles.
REQ-018 eff_max SHALL equal max_value, except that max_value=0 SHALL be treated as 1 (sample_enable high every RUN cycle).
REQ-019 The first sample_enable after IDLE -> RUN SHALL occur eff_max cycles after the transition edge.
REQ-020 sample_cnt SHALL increment modulo 16 on each sample_enable.
REQ-021 bit_tick SHALL be 1 when sample_enable=1 and sample_cnt=15.
REQ-022 mid_tick SHALL be 1 when sample_enable=1 and sample_cnt=7.
REQ-023 mid_tick and bit_tick SHALL be combinational from registered state, with no extra latency relative to sample_enable.
REQ-024 max_value SHALL be registered internally every cycle.
REQ-025 When the registered value differs from the incoming value, div_cnt and sample_cnt SHALL clear on the next edge, so the new rate starts a clean period.
REQ-026 On a max_value change, no partial or stretched pulse SHALL be emitted.
REQ-027 A resync in RUN SHALL clear div_cnt and sample_cnt on the next edge.
REQ-028 A resync in RUN SHALL suppress any sample_enable due in that same cycle.
REQ-029 resync SHALL have priority over normal counting and over a max_value change.
REQ-030 resync in IDLE SHALL have no effect.
REQ-031 If enable falls in the same cycle as resync, the IDLE behaviour SHALL win.
REQ-032 If max_value drops below the current div_cnt, the change-clear of REQ-025 SHALL prevent overrun; div_cnt SHALL never exceed eff_max-1 for more than one cycle.
REQ-033 Counter widths SHALL be 16 bits for div_cnt and 4 bits for sample_cnt, with wrap-around by explicit load or modulo only, never by overflow.

Reset
REQ-034 While reset=0: state=IDLE, div_cnt=0, sample_cnt=0, registered max_value=0, and all outputs 0, regardless of clk.
REQ-035 Deasserting reset mid-period SHALL restart from IDLE, with no pulse emitted at the reset release edge.

Verification
REQ-036 Basic rate: max_value=0x0036, enable=1 for 2000 cycles -> sample_enable every 54 cycles (first at cycle 54), bit_tick every 864 cycles, mid_tick 432 cycles before each bit_tick.
REQ-037 Slowest rate: max_value=0x5161 -> 20833-cycle sample_enable spacing across at least 17 pulses, with sample_cnt wrapping 15 -> 0 exactly once at bit_tick.
REQ-038 Rate change: with max_value=0x0036 running, switch to 0x006C at div_cnt=30 -> counters clear one cycle later, next sample_enable 108 cycles after the clear, no pulse in between.
REQ-039 Resync: pulse resync at sample_cnt=11 -> sample_cnt=0 next cycle, mid_tick exactly 8*54 cycles later, and no sample_enable in the resync cycle even if div_cnt=53.
REQ-040 Edge cases: max_value=0 -> sample_enable high every RUN cycle and bit_tick every 16 cycles; enable dropped mid-count -> all outputs 0 and counters 0 next cycle.
REQ-041 Async reset: assert reset low between clk edges during RUN -> outputs and counters 0 immediately; release -> IDLE, no pulse at the release edge.
